// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory fetcher feeding a 4-entry
// instruction queue, with redirect flush, stale-response draining and halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt
);

  localparam logic [2:0] QFull = 3'(DEPTH);

  typedef enum logic [1:0] {StRun, StWait, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail;
  logic [2:0]  count_q, count_d;
  logic [15:0] data_q [4];
  logic [15:0] data_d [4];
  logic [15:0] pc_q   [4];
  logic [15:0] pc_d   [4];
  logic        enq, deq;

  always_comb begin
    // Gating with rst_n keeps the request low while reset is held.
    imem_req    = rst_n && (state_q == StRun) && (count_q < QFull);
    imem_addr   = imem_req ? fetch_pc_q : 16'h0000;
    instr_valid = (count_q != 3'd0) && (state_q != StHalt);
    instr       = instr_valid ? data_q[head_q] : 16'h0000;
    instr_pc    = instr_valid ? pc_q[head_q] : 16'h0000;
    tail        = head_q + count_q[1:0];
    deq         = instr_valid && instr_ready;
    enq         = (state_q == StWait) && imem_rvalid;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    count_d    = count_q;
    data_d     = data_q;
    pc_d       = pc_q;

    if (hlt) begin
      state_d = StHalt;
      head_d  = 2'd0;
      count_d = 3'd0;
    end else if (state_q == StHalt) begin
      state_d = StHalt;
    end else if (redirect) begin
      head_d     = 2'd0;
      count_d    = 3'd0;
      fetch_pc_d = redirect_pc;
      unique case (state_q)
        // A request issued in the redirect cycle is still outstanding and must be drained.
        StRun:   state_d = imem_req ? StDrain : StRun;
        StWait:  state_d = imem_rvalid ? StRun : StDrain;
        StDrain: state_d = imem_rvalid ? StRun : StDrain;
        default: state_d = state_q;
      endcase
    end else begin
      unique case (state_q)
        StRun: begin
          if (imem_req) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 16'd1;
            state_d    = StWait;
          end
        end
        StWait:  if (imem_rvalid) state_d = StRun;
        StDrain: if (imem_rvalid) state_d = StRun;
        default: state_d = state_q;
      endcase
      if (enq) begin
        data_d[tail] = imem_rdata;
        pc_d[tail]   = req_pc_q;
      end
      if (deq) head_d = head_q + 2'd1;
      count_d = count_q + {2'b00, enq} - {2'b00, deq};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 16'h0000;
      head_q     <= 2'd0;
      count_q    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= 16'h0000;
        pc_q[i]   <= 16'h0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory, an expected-stream queue
// refilled on every reset/redirect, and a monitor that checks every accepted instruction.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_req, imem_rvalid, instr_valid, instr_ready, redirect, hlt;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;

  logic        w_rst_n, w_req, w_rvalid, w_valid, w_redirect, w_hlt, w_pend;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc, w_paddr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          resp_cnt = 0;
  int          del_cnt  = 0;
  logic [15:0] last_pc;
  int          due_q[$];
  logic [15:0] addr_q[$];
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .hlt(hlt)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .instr(w_instr), .instr_pc(w_pc),
    .instr_valid(w_valid), .instr_ready(1'b1), .redirect(w_redirect),
    .redirect_pc(16'h0200), .hlt(w_hlt)
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decoder stream after a reset or redirect: consecutive words from pc.
  task automatic push_exp(input logic [15:0] pc);
    logic [15:0] a;
    exp_q.delete();
    a = pc;
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({a, word_at(a)});
      a = a + 16'd1;
    end
  endtask

  // Memory for the main DUT: response exactly lat cycles after the request cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      due_q.delete();
      addr_q.delete();
      imem_rvalid = 1'b0;
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(addr_q[0]);
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
      resp_cnt++;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'hDEAD;
    end
    #1;
    if (imem_req) begin
      check("one_outstanding", due_q.size(), 0);
      due_q.push_back(cyc + lat);
      addr_q.push_back(imem_addr);
    end
  end

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (rst_n && instr_valid && instr_ready && !redirect && !hlt) begin
      del_cnt++;
      last_pc = instr_pc;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e[31:16]);
        check("instr", instr, e[15:0]);
      end
    end
    if (rst_n && !instr_valid) check("idle_zero", {instr_pc, instr}, 0);
  end

  // One-cycle memory for the wrap/halt instance.
  always @(negedge clk) begin
    w_rvalid = w_pend;
    w_rdata  = word_at(w_paddr);
    #1;
    w_pend  = w_req;
    w_paddr = w_addr;
  end

  task automatic do_reset(input logic [15:0] pc);
    @(negedge clk);
    rst_n    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    @(negedge clk);
    resp_cnt = 0;
    del_cnt  = 0;
    push_exp(pc);
    rst_n = 1'b1;
  endtask

  task automatic wait_del(input string name, input int target, input int budget);
    int n = 0;
    while (del_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, del_cnt >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          tgt;
    logic        found;
    logic [15:0] wexp [2];
    int          seen;

    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    w_rst_n = 1'b0; w_redirect = 1'b0; w_hlt = 1'b0; w_pend = 1'b0; w_paddr = '0;

    // Stream: first request at reset release, first instr_valid two cycles later.
    lat = 1; instr_ready = 1'b1;
    do_reset(16'h0000);
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 16'h0000);
    @(negedge clk); #3;
    check("valid_cycle1", instr_valid, 0);
    @(negedge clk); #3;
    check("valid_cycle2", instr_valid, 1);
    check("valid_cycle2_pc", instr_pc, 16'h0000);
    wait_del("stream_8", 8, 60);

    // Backpressure: queue fills to exactly 4, then drains in order.
    lat = 1; instr_ready = 1'b0;
    do_reset(16'h0000);
    repeat (20) @(negedge clk);
    #3;
    check("bp_queued", resp_cnt - del_cnt, 4);
    check("bp_no_req", imem_req, 0);
    check("bp_valid", instr_valid, 1);
    @(negedge clk);
    instr_ready = 1'b1;
    wait_del("bp_drain", 12, 80);

    // Redirect while a 3-cycle request is in flight.
    lat = 3; instr_ready = 1'b1;
    do_reset(16'h0000);
    wait_del("rif_warm", 2, 40);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (imem_req) break;
    end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040; push_exp(16'h0040);
    tgt = del_cnt + 1;
    @(negedge clk);
    redirect = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (imem_req) break;
      @(negedge clk);
    end
    check("rif_req_addr", imem_addr, 16'h0040);
    wait_del("rif_deliver", tgt, 30);
    check("rif_first_pc", last_pc, 16'h0040);

    // Redirect coinciding with a response and a dequeue.
    lat = 2; instr_ready = 1'b0;
    do_reset(16'h0000);
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (resp_cnt >= 2 && due_q.size() > 0 && due_q[0] == cyc + 1) begin
        found = 1'b1;
        break;
      end
    end
    check("coinc_setup", found, 1);
    @(negedge clk);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234; push_exp(16'h1234);
    #3;
    check("coinc_rvalid", imem_rvalid, 1);
    check("coinc_valid_before", instr_valid, 1);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("coinc_empty", instr_valid, 0);
    check("coinc_req", imem_req, 1);
    check("coinc_addr", imem_addr, 16'h1234);
    wait_del("coinc_deliver", del_cnt + 2, 30);

    // Randomized latency, backpressure and redirects against the stream model.
    instr_ready = 1'b1;
    do_reset(16'h0000);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lat         = $urandom_range(1, 4);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
        push_exp(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b1;
    check("random_progress", del_cnt > 150, 1);

    // Wrap from RESET_PC=FFFF, halt beating redirect, restart by reset.
    wexp[0] = 16'hFFFF; wexp[1] = 16'h0000;
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    check("wrap_first_req", w_req, 1);
    check("wrap_first_addr", w_addr, 16'hFFFF);
    seen = 0;
    for (int n = 0; n < 20 && seen < 2; n++) begin
      @(negedge clk); #2;
      if (w_valid) begin
        check("wrap_pc", w_pc, wexp[seen]);
        check("wrap_instr", w_instr, word_at(wexp[seen]));
        seen++;
      end
    end
    check("wrap_seen", seen, 2);
    @(negedge clk);
    w_hlt = 1'b1; w_redirect = 1'b1;
    @(negedge clk);
    w_hlt = 1'b0; w_redirect = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      check("halt_req", w_req, 0);
      check("halt_valid", w_valid, 0);
      @(negedge clk);
    end
    w_rst_n = 1'b0;
    #1;
    check("halt_rst_req", w_req, 0);
    check("halt_rst_addr", w_addr, 0);
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    check("restart_req", w_req, 1);
    check("restart_addr", w_addr, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries; only the value 4 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request; accepted by memory in the same cycle.
REQ-006 SHALL have port imem_addr  output  16  word address of the request; valid while imem_req=1.
REQ-007 SHALL have port imem_rvalid  input  1  response strobe, at least 1 cycle after the request.
REQ-008 SHALL have port imem_rdata  input  16  instruction word; valid while imem_rvalid=1.
REQ-009 SHALL have port instr  output  16  queue-head instruction, presented to the control decoder.
REQ-010 SHALL have port instr_pc  output  16  word address of instr.
REQ-011 SHALL have port instr_valid  output  1  queue non-empty and not halted.
REQ-012 SHALL have port instr_ready  input  1  decoder accepts instr this cycle.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  16  new fetch address; valid while redirect=1.
REQ-015 SHALL have port hlt  input  1  the decoder has decoded HLT.

Function
REQ-016 SHALL have states RUN, WAIT (one request outstanding), DRAIN (outstanding response to be discarded) and HALT.
REQ-017 SHALL allow at most one outstanding memory request at any time.
REQ-018 In RUN, imem_req SHALL be 1 iff queue count < DEPTH; imem_addr=fetch_pc; on request: fetch_pc+=1 (16-bit wrap, 16'hFFFF->16'h0000), go to WAIT.
REQ-019 In WAIT, on imem_rvalid SHALL enqueue {imem_rdata, address of the request} and return to RUN; the request for the next word may issue the following cycle.
REQ-020 A dequeue SHALL occur when instr_valid & instr_ready; the head advances next cycle.
REQ-021 Enqueue and dequeue in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-022 Latency: imem_rvalid in cycle N into an empty queue SHALL give instr_valid=1 in cycle N+1.
REQ-023 instr/instr_pc SHALL drive 16'h0000 when instr_valid=0.
REQ-024 A redirect SHALL empty the queue and set fetch_pc=redirect_pc at the next edge; any dequeue in that cycle is void.
REQ-025 A redirect with a request outstanding (WAIT, or rvalid not yet seen) SHALL go to DRAIN; the next imem_rvalid is discarded; RUN resumes the cycle after.
REQ-026 A redirect coinciding with imem_rvalid SHALL discard that response and go directly to RUN.
REQ-027 A redirect while in DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-028 When hlt=1, HALT SHALL be entered at the next edge from any state, with precedence over redirect.
REQ-029 In HALT: imem_req=0, instr_valid=0, queue flushed, and any late imem_rvalid ignored; only reset exits.
REQ-030 Full queue: no request issues; the pending request counts as a reserved slot, so enqueue never overflows.

Reset
REQ-031 While rst_n=0, state SHALL be RUN, fetch_pc=RESET_PC, queue empty, no outstanding request, imem_req=0, imem_addr=16'h0000, instr=16'h0000, instr_pc=16'h0000, and instr_valid=0.
REQ-032 The first request SHALL issue at the first edge after rst_n rises, with imem_addr=RESET_PC.
REQ-033 Reset asserted mid-WAIT or mid-DRAIN SHALL abandon the transaction; a response arriving after reset is ignored until a request has issued.

Verification
REQ-034 Stream test: 1-cycle memory, instr_ready=1, words A0..A7 at 0..7 -> decoder receives A0..A7 in order with instr_pc 0..7; first instr_valid 2 cycles after the first request.
REQ-035 Backpressure test: instr_ready=0 for 20 cycles -> exactly 4 words queued, imem_req=0 afterwards; release -> in-order delivery with no loss or duplication.
REQ-036 Redirect-in-flight test: 3-cycle memory, redirect to 16'h0040 while WAIT -> stale word dropped, next instr_pc=16'h0040.
REQ-037 Coincident test: redirect and imem_rvalid in the same cycle, plus a dequeue -> response dropped, queue empty, next imem_addr=redirect_pc.
REQ-038 Wrap/halt test: RESET_PC=16'hFFFF -> instr_pc sequence FFFF, 0000; hlt with redirect in the same cycle -> HALT, imem_req=0 forever; rst_n low-high -> fetch restarts at RESET_PC.
